// File: rtl/line_buffer_3row.sv
// line_buffer_3row: turns a raster pixel stream into three vertically aligned
// row streams (two rows back, one row back, current) for a 3x3 window stage.
// Two line memories hold the previous two rows; every accepted pixel reads
// both memories at its column, shifts the column down one memory and stores
// itself, so the output triple appears exactly one clock after the pixel.
//
// Handshake: valid_in qualifies din on every rising edge; there is no
// backpressure. valid_out qualifies dout1..dout3 for exactly the cycle it is
// high. Gaps (valid_in low) are legal anywhere; state and data outputs hold.
module line_buffer_3row #(
   parameter int WIDTH      = 24,
   parameter int PIC_WIDTH  = 250,
   parameter int PIC_HEIGHT = 250
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] din,
   output logic             valid_out,
   output logic [WIDTH-1:0] dout1,
   output logic [WIDTH-1:0] dout2,
   output logic [WIDTH-1:0] dout3,
   output logic             frame_done
);

   localparam int CW = (PIC_WIDTH  > 1) ? $clog2(PIC_WIDTH)  : 1;
   localparam int RW = (PIC_HEIGHT > 1) ? $clog2(PIC_HEIGHT) : 1;

   localparam logic [CW-1:0] COL_LAST  = CW'(PIC_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(PIC_HEIGHT - 1);
   localparam logic [RW-1:0] ROW_FIRST_VALID = RW'(2);

   // raster position of the pixel that is accepted next
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;

   // lineA holds row r-1, lineB holds row r-2 (contents are never reset)
   logic [WIDTH-1:0] line_a_q [PIC_WIDTH];
   logic [WIDTH-1:0] line_b_q [PIC_WIDTH];

   // output registers
   logic [WIDTH-1:0] dout1_q, dout2_q, dout3_q;
   logic             valid_out_q, frame_done_q;

   // old memory contents at the current column (read before this cycle's write)
   logic [WIDTH-1:0] rd_a, rd_b;
   logic             col_last, row_last;

   assign rd_a     = line_a_q[col_q];
   assign rd_b     = line_b_q[col_q];
   assign col_last = (col_q == COL_LAST);
   assign row_last = (row_q == ROW_LAST);

   // next raster position: advance on accepted pixels, wrap at row and frame end
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (valid_in) begin
         if (col_last) begin
            col_d = '0;
            if (row_last) begin
               row_d = '0;
            end else begin
               row_d = row_q + RW'(1);
            end
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   // raster position registers; reset abandons any frame in progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   // line memories: shift the column down one row and store the new pixel;
   // nonblocking updates give read-before-write at the shared address
   always_ff @(posedge clk) begin
      if (valid_in) begin
         line_b_q[col_q] <= rd_a;
         line_a_q[col_q] <= din;
      end
   end

   // output triple and flags, one clock after the accepted pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout1_q      <= '0;
         dout2_q      <= '0;
         dout3_q      <= '0;
         valid_out_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         // flags are single-cycle and drop during gaps; data holds
         valid_out_q  <= valid_in && (row_q >= ROW_FIRST_VALID);
         frame_done_q <= valid_in && col_last && row_last;
         if (valid_in) begin
            dout1_q <= rd_b;
            dout2_q <= rd_a;
            dout3_q <= din;
         end
      end
   end

   assign dout1      = dout1_q;
   assign dout2      = dout2_q;
   assign dout3      = dout3_q;
   assign valid_out  = valid_out_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Directed bench for line_buffer_3row on a 4x4 frame of 8-bit pixels whose
// value is 16*row + col. Expected triples are derived from the raster
// position of each pixel fed in.
module tb_line_buffer_3row;

   localparam int W  = 8;
   localparam int PW = 4;
   localparam int PH = 4;

   logic         clk;
   logic         rst_n;
   logic         valid_in;
   logic [W-1:0] din;
   logic         valid_out;
   logic [W-1:0] dout1, dout2, dout3;
   logic         frame_done;

   int n_cmp;
   int n_bad;

   line_buffer_3row #(
      .WIDTH      (W),
      .PIC_WIDTH  (PW),
      .PIC_HEIGHT (PH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_in   (valid_in),
      .din        (din),
      .valid_out  (valid_out),
      .dout1      (dout1),
      .dout2      (dout2),
      .dout3      (dout3),
      .frame_done (frame_done)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // single comparison point
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // drive one pixel on the falling edge, sample #1 after the rising edge
   task automatic push(input logic [W-1:0] pix);
      @(negedge clk);
      valid_in = 1'b1;
      din      = pix;
      @(posedge clk);
      #1;
   endtask

   // one idle cycle; data outputs must hold the previous triple
   task automatic idle_check(input string tag, input logic [W-1:0] e1,
                             input logic [W-1:0] e2, input logic [W-1:0] e3);
      @(negedge clk);
      valid_in = 1'b0;
      din      = 8'hEE;
      @(posedge clk);
      #1;
      check({tag, " valid_out"}, 32'(valid_out), 32'd0);
      check({tag, " frame_done"}, 32'(frame_done), 32'd0);
      check({tag, " dout1"}, 32'(dout1), 32'(e1));
      check({tag, " dout2"}, 32'(dout2), 32'(e2));
      check({tag, " dout3"}, 32'(dout3), 32'(e3));
   endtask

   // stream the first n_pix pixels of a frame, checking every output beat;
   // gap_pix >= 0 inserts three idle cycles right after that pixel value
   task automatic stream(input int frame, input int n_pix, input int gap_pix);
      int r, c;
      logic [W-1:0] p;
      string tag;
      for (int k = 0; k < n_pix; k++) begin
         r = k / PW;
         c = k % PW;
         p = W'(16 * r + c);
         push(p);
         tag = $sformatf("f%0d px%02h", frame, p);
         check({tag, " valid_out"}, 32'(valid_out), 32'(r >= 2));
         check({tag, " frame_done"}, 32'(frame_done), 32'(r == PH - 1 && c == PW - 1));
         if (r >= 2) begin
            check({tag, " dout1"}, 32'(dout1), 32'(16 * (r - 2) + c));
            check({tag, " dout2"}, 32'(dout2), 32'(16 * (r - 1) + c));
         end
         check({tag, " dout3"}, 32'(dout3), 32'(p));
         if (gap_pix >= 0 && int'(p) == gap_pix) begin
            for (int g = 0; g < 3; g++) begin
               idle_check($sformatf("f%0d gap%0d", frame, g),
                          W'(16 * (r - 2) + c), W'(16 * (r - 1) + c), p);
            end
         end
      end
   endtask

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      rst_n    = 1'b0;
      valid_in = 1'b1;
      din      = 8'hFF;

      // reset with active input: everything stays cleared
      repeat (3) @(posedge clk);
      #1;
      check("rst valid_out", 32'(valid_out), 32'd0);
      check("rst frame_done", 32'(frame_done), 32'd0);
      check("rst dout1", 32'(dout1), 32'd0);
      check("rst dout2", 32'(dout2), 32'd0);
      check("rst dout3", 32'(dout3), 32'd0);
      @(negedge clk);
      valid_in = 1'b0;
      rst_n    = 1'b1;

      // frame 1 with a mid-row gap after 0x22
      stream(1, PW * PH, 'h22);
      // frame 2 back to back, no idle cycles
      stream(2, PW * PH, -1);

      // frame 3 abandoned after 0x31 by a reset pulse
      stream(3, 3 * PW + 2, -1);
      @(negedge clk);
      valid_in = 1'b0;
      rst_n    = 1'b0;
      @(posedge clk);
      #1;
      check("midrst valid_out", 32'(valid_out), 32'd0);
      check("midrst dout3", 32'(dout3), 32'd0);
      check("midrst dout2", 32'(dout2), 32'd0);
      check("midrst dout1", 32'(dout1), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // frame 4 must restart at row 0, column 0
      stream(4, PW * PH, -1);

      @(negedge clk);
      valid_in = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
